arb_requester_port: RTL and testbench

- Requester-side endpoint for the variable/round-robin arbiter family.
- Accepts a val/rdy message stream of possibly multi-beat packets and buffers the beats in a small FIFO.
- Drives one req line into an arbiter and transfers one beat per cycle in which the arbiter returns a grant.
- Holds a lock output across multi-beat packets so arbitration logic can keep the grant stable.

---
 rtl/arb_requester_port_if.sv | 27 ++
 rtl/arb_requester_port.sv | 110 +++++++++++
 tb/tb_arb_requester_port.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/arb_requester_port_if.sv
// Handshake bundle for one arbiter requester port: the val/rdy beat stream
// going in and the req/grant/lock arbiter signals with the head beat going out.
interface arb_requester_port_if #(
  parameter int p_msg_nbits = 32
);
  logic                   in_val;
  logic                   in_rdy;
  logic [p_msg_nbits-1:0] in_msg;
  logic                   in_last;
  logic                   req;
  logic                   grant;
  logic                   lock;
  logic [p_msg_nbits-1:0] out_msg;
  logic                   out_last;

  // Beat producer and arbiter side.
  modport master (
    output in_val, in_msg, in_last, grant,
    input  in_rdy, req, lock, out_msg, out_last
  );

  // Requester port side.
  modport slave (
    input  in_val, in_msg, in_last, grant,
    output in_rdy, req, lock, out_msg, out_last
  );
endinterface

// File: rtl/arb_requester_port.sv
// Requester endpoint for the arbiter family: buffers val/rdy packet beats in a FIFO,
// requests the arbiter and holds lock across multi-beat packets.
// Optional starvation monitor (starve output) enabled by ARB_REQUESTER_PORT_STARVE_CNT_EN.
module arb_requester_port #(
  parameter int p_msg_nbits     = 32,
  parameter int p_depth         = 4,
  parameter int p_starve_thresh = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  arb_requester_port_if.slave        bus,
  output logic [$clog2(p_depth):0]   count,
  output logic                       err,
  output logic                       state_dbg
`ifdef ARB_REQUESTER_PORT_STARVE_CNT_EN
  ,
  output logic                       starve
`endif
);

  localparam int AW = $clog2(p_depth);
  localparam int CW = AW + 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  // Handshake: a beat enters on in_val && in_rdy at a rising edge; a beat leaves
  // on req && grant at a rising edge. Both may happen in the same cycle.
  logic [p_msg_nbits:0] mem [p_depth];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [0:0]           state;
  logic                 push;
  logic                 xfer;
  logic                 head_last;

  assign bus.in_rdy   = (count < CW'(p_depth));
  assign bus.req      = (count != '0);
  assign bus.lock     = (state == LOCKED);
  assign bus.out_msg  = mem[rd_ptr][p_msg_nbits:1];
  assign bus.out_last = mem[rd_ptr][0];
  assign head_last    = mem[rd_ptr][0];
  assign state_dbg    = state;

  assign push = bus.in_val && bus.in_rdy;
  assign xfer = bus.req && bus.grant;

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_msg, bus.in_last};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (xfer) rd_ptr <= rd_ptr + 1'b1;
      case ({push, xfer})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else if (xfer) begin
      state <= head_last ? IDLE : LOCKED;
    end
  end

  // A grant with nothing requested is an arbiter protocol violation; latch it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (bus.grant && !bus.req) begin
      err <= 1'b1;
    end
  end

`ifdef ARB_REQUESTER_PORT_STARVE_CNT_EN
  localparam int SW = $clog2(p_starve_thresh + 1) + 1;

  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_cnt_nxt;

  always_comb begin
    starve_cnt_nxt = '0;
    if (bus.req && !bus.grant) begin
      starve_cnt_nxt = (starve_cnt == '1) ? starve_cnt : starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      starve     <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      starve     <= (starve_cnt_nxt > SW'(p_starve_thresh));
    end
  end
`endif

endmodule

// File: tb/tb_arb_requester_port.sv
// Self-checking bench for arb_requester_port: a reference model plus an
// expected-beat queue checked against the FIFO head every cycle.
module tb_arb_requester_port;
  localparam int W      = 32;
  localparam int DEPTH  = 4;
  localparam int THRESH = 15;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic [CW-1:0] count;
  logic          err;
  logic          state_dbg;
`ifdef ARB_REQUESTER_PORT_STARVE_CNT_EN
  logic          starve;
`endif

  arb_requester_port_if #(.p_msg_nbits(W)) bus ();

  arb_requester_port #(
    .p_msg_nbits(W), .p_depth(DEPTH), .p_starve_thresh(THRESH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .count(count), .err(err),
    .state_dbg(state_dbg)
`ifdef ARB_REQUESTER_PORT_STARVE_CNT_EN
    , .starve(starve)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state: expected {msg,last} beats and model registers
  logic [W:0] exp_q[$];
  int         m_count;
  logic       m_lock;
  logic       m_err;
  int         m_scnt;
  logic       m_starve;
  int         n_checks;
  int         n_fail;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_count  = 0;
    m_lock   = 1'b0;
    m_err    = 1'b0;
    m_scnt   = 0;
    m_starve = 1'b0;
  endtask

  // Drive one cycle of inputs, check outputs before the edge, advance the model.
  task automatic step(input logic val, input logic [W-1:0] msg, input logic last,
                      input logic gnt);
    logic [W:0] head;
    logic       do_push;
    logic       do_pop;
    bus.in_val  = val;
    bus.in_msg  = msg;
    bus.in_last = last;
    bus.grant   = gnt;
    @(negedge clk);
    check_eq("in_rdy", bus.in_rdy, m_count < DEPTH);
    check_eq("req", bus.req, m_count != 0);
    check_eq("lock", bus.lock, m_lock);
    check_eq("state", state_dbg, m_lock);
    check_eq("count", count, m_count);
    check_eq("err", err, m_err);
`ifdef ARB_REQUESTER_PORT_STARVE_CNT_EN
    check_eq("starve", starve, m_starve);
`endif
    do_push = val && (m_count < DEPTH);
    do_pop  = gnt && (m_count != 0);
    if (m_count != 0) begin
      head = exp_q[0];
      check_eq("out_msg", bus.out_msg, head[W:1]);
      check_eq("out_last", bus.out_last, head[0]);
    end
    if (gnt && m_count == 0) m_err = 1'b1;
    if (m_count != 0 && !gnt) m_scnt = (m_scnt == 31) ? 31 : m_scnt + 1;
    else                      m_scnt = 0;
    m_starve = (m_scnt > THRESH);
    if (do_pop) begin
      head   = exp_q.pop_front();
      m_lock = !head[0];
    end
    if (do_push) exp_q.push_back({msg, last});
    m_count = m_count + int'(do_push) - int'(do_pop);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Assert reset asynchronously mid-cycle and hold it for n edges with in_val=1.
  task automatic apply_reset(input int n);
    bus.in_val  = 1'b1;
    bus.in_msg  = 32'hDEAD_BEEF;
    bus.in_last = 1'b0;
    bus.grant   = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check_eq("rst_lock", bus.lock, 1'b0);
    check_eq("rst_count", count, 0);
    check_eq("rst_req", bus.req, 1'b0);
    repeat (n) @(posedge clk);
    #1;
    check_eq("rst_hold_count", count, 0);
    check_eq("rst_hold_err", err, 1'b0);
    check_eq("rst_hold_lock", bus.lock, 1'b0);
    reset = 1'b1;
    bus.in_val = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_clear();
    reset       = 1'b1;
    bus.in_val  = 1'b0;
    bus.in_msg  = '0;
    bus.in_last = 1'b0;
    bus.grant   = 1'b0;
    @(posedge clk);
    #1;
    apply_reset(3);
    idle_cycles(1);

    // Single-beat packet
    step(1'b1, 32'hA5, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    idle_cycles(2);

    // Three-beat packet granted back to back
    step(1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b1, 32'h2, 1'b0, 1'b1);
    step(1'b1, 32'h3, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    idle_cycles(2);

    // Three-beat packet with a gap: FIFO empty while lock is held
    step(1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    idle_cycles(2);
    step(1'b1, 32'h2, 1'b0, 1'b0);
    step(1'b1, 32'h3, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    idle_cycles(1);

    // Fill, overflow attempt, pop while full, push+pop, drain across the wrap
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h10 + i, 1'(i == DEPTH - 1), 1'b0);
    step(1'b1, 32'h99, 1'b1, 1'b0);
    step(1'b1, 32'h98, 1'b1, 1'b1);
    step(1'b1, 32'h20, 1'b1, 1'b1);
    check_eq("full_simul_count", count, 3);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h30 + i, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
    idle_cycles(1);

    // Reset mid-packet discards beats and drops lock at once
    step(1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b1, 32'h41, 1'b0, 1'b1);
    apply_reset(2);
    idle_cycles(1);

`ifdef ARB_REQUESTER_PORT_STARVE_CNT_EN
    // Starvation: one beat held ungranted past the threshold, then granted
    step(1'b1, 32'h55, 1'b1, 1'b0);
    idle_cycles(THRESH + 3);
    check_eq("starve_set", starve, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check_eq("starve_clr", starve, 1'b0);
    idle_cycles(1);
`endif

    // Spurious grant with an empty FIFO
    step(1'b0, '0, 1'b0, 1'b1);
    check_eq("spur_err", err, 1'b1);
    check_eq("spur_count", count, 0);
    check_eq("spur_state", state_dbg, 1'b0);
    idle_cycles(3);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
